// File: rtl/fairy_div_pkg.sv
// fairy_div_pkg: shared state encoding and iteration count for the radix-2 divider
package fairy_div_pkg;
  localparam int DIV_ITER = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_e;
endpackage

// File: rtl/fairy_div_if.sv
// fairy_div_if: execute-stage divide handshake; master is the requester, slave the divider
interface fairy_div_if import fairy_div_pkg::*; #(parameter int WIDTH = DIV_ITER);
  logic             ready_i, signed_i, flush_i, valid_o, busy_o;
  logic [WIDTH-1:0] dividend_i, divisor_i, quotient_o, remainder_o;
  modport master (output ready_i, signed_i, flush_i, dividend_i, divisor_i,
                  input  valid_o, busy_o, quotient_o, remainder_o);
  modport slave  (input  ready_i, signed_i, flush_i, dividend_i, divisor_i,
                  output valid_o, busy_o, quotient_o, remainder_o);
endinterface

// File: rtl/fairy_div_step.sv
// fairy_div_step: one combinational restoring iteration on the {rem, quo} pair
module fairy_div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] trial;
  always_comb begin
    trial = {rem_i, quo_i[WIDTH-1]} - {1'b0, dvs_i};
    rem_o = trial[WIDTH] ? {rem_i[WIDTH-2:0], quo_i[WIDTH-1]} : trial[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
  end
endmodule

// File: rtl/fairy_div_unit.sv
// fairy_div_unit: iterative signed/unsigned restoring divider with flush, one bit per cycle
module fairy_div_unit import fairy_div_pkg::*; #(parameter int WIDTH = DIV_ITER) (
  input logic        clk,
  input logic        reset_n,
  fairy_div_if.slave d
);
  localparam int CW = $clog2(WIDTH);
  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             a_neg, b_neg, last;
  assign a_neg = d.signed_i & d.dividend_i[WIDTH-1];
  assign b_neg = d.signed_i & d.divisor_i[WIDTH-1];
  assign last  = count_q == CW'(WIDTH - 1);
  fairy_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q), .quo_i(quo_q), .dvs_i(dvs_q), .rem_o(rem_nx), .quo_o(quo_nx)
  );
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    if (d.flush_i) state_d = IDLE;
    else case (state_q)
      IDLE: if (d.ready_i) begin
        state_d = BUSY;
        count_d = '0;
        rem_d   = '0;
        quo_d   = a_neg ? -d.dividend_i : d.dividend_i;
        dvs_d   = b_neg ? -d.divisor_i : d.divisor_i;
        qneg_d  = a_neg ^ b_neg;
        rneg_d  = a_neg;
      end
      // a requester that lets go of ready_i mid-divide abandons it like a flush
      BUSY: if (!d.ready_i) state_d = IDLE;
      else begin
        rem_d   = rem_nx;
        quo_d   = quo_nx;
        count_d = count_q + CW'(1);
        if (last) begin
          state_d     = DONE;
          quotient_d  = qneg_q ? -quo_nx : quo_nx;
          remainder_d = rneg_q ? -rem_nx : rem_nx;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end
  assign d.valid_o     = state_q == DONE;
  assign d.busy_o      = state_q != IDLE;
  assign d.quotient_o  = quotient_q;
  assign d.remainder_o = remainder_q;
endmodule

// File: tb/tb_fairy_div_unit.sv
// tb_fairy_div_unit: directed checks of latency, signed/unsigned results, flush, back-to-back and reset
module tb_fairy_div_unit;
  logic clk, reset_n;
  int   checks = 0, failures = 0;
  fairy_div_if #(.WIDTH(32)) dif();
  fairy_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset_n(reset_n), .d(dif));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er, input string nm);
    int n;
    @(posedge clk); #1;
    dif.ready_i = 1'b1; dif.signed_i = s; dif.dividend_i = a; dif.divisor_i = b;
    @(posedge clk); #1;
    dif.dividend_i = $urandom; dif.divisor_i = $urandom; dif.signed_i = ~s;
    n = 0;
    while (!dif.valid_o && n < 40) begin @(posedge clk); #1; n++; end
    dif.ready_i = 1'b0;
    checks++; if (n != 32) begin failures++; $display("FAIL %s latency got=%0d exp=32", nm, n); end
    checks++; if (dif.quotient_o !== eq) begin failures++; $display("FAIL %s quotient got=%h exp=%h", nm, dif.quotient_o, eq); end
    checks++; if (dif.remainder_o !== er) begin failures++; $display("FAIL %s remainder got=%h exp=%h", nm, dif.remainder_o, er); end
    @(posedge clk); #1;
    checks++;
    if (dif.valid_o !== 1'b0 || dif.quotient_o !== eq || dif.remainder_o !== er) begin
      failures++; $display("FAIL %s hold valid=%b q=%h r=%h exp valid=0 q=%h r=%h", nm, dif.valid_o, dif.quotient_o, dif.remainder_o, eq, er);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    dif.ready_i = 1'b0; dif.signed_i = 1'b0; dif.flush_i = 1'b0;
    dif.dividend_i = '0; dif.divisor_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dif.valid_o, dif.busy_o} !== 2'b00 || dif.quotient_o !== 0 || dif.remainder_o !== 0) begin
      failures++; $display("FAIL reset valid=%b busy=%b q=%h r=%h exp all 0", dif.valid_o, dif.busy_o, dif.quotient_o, dif.remainder_o);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_unsigned;
    do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "u_100_7");
    do_div(32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, "u_div0");
    do_div(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, "u_max_1");
    do_div(32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, "u_big_2");
  endtask

  task automatic test_signed;
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, "s_m7_2");
    do_div(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, "s_7_m2");
    do_div(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3, 32'hFFFFFFFF, "s_m7_m2");
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, "s_min_m1");
  endtask

  task automatic test_flush;
    int  n;
    logic seen;
    do_div(32'd50, 32'd6, 1'b0, 32'd8, 32'd2, "f_prev");
    @(posedge clk); #1;
    dif.ready_i = 1'b1; dif.signed_i = 1'b0; dif.dividend_i = 32'd1000; dif.divisor_i = 32'd10;
    @(posedge clk); #1;
    seen = 1'b0;
    repeat (9) begin @(posedge clk); #1; seen |= dif.valid_o; end
    dif.flush_i = 1'b1;
    @(posedge clk); #1;
    dif.flush_i = 1'b0; dif.ready_i = 1'b0; seen |= dif.valid_o;
    checks++; if (dif.busy_o !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", dif.busy_o); end
    @(posedge clk); #1;
    dif.ready_i = 1'b1; seen |= dif.valid_o;
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_valid got=%b exp=0", seen); end
    checks++;
    if (dif.quotient_o !== 32'd8 || dif.remainder_o !== 32'd2) begin
      failures++; $display("FAIL flush_retain q=%h r=%h exp q=8 r=2", dif.quotient_o, dif.remainder_o);
    end
    @(posedge clk); #1;
    n = 0;
    while (!dif.valid_o && n < 40) begin @(posedge clk); #1; n++; end
    dif.ready_i = 1'b0;
    checks++; if (n != 32) begin failures++; $display("FAIL flush_rereq latency got=%0d exp=32", n); end
    checks++;
    if (dif.quotient_o !== 32'd100 || dif.remainder_o !== 32'd0) begin
      failures++; $display("FAIL flush_rereq result q=%h r=%h exp q=64 r=0", dif.quotient_o, dif.remainder_o);
    end
    @(posedge clk); #1;
    dif.ready_i = 1'b1; dif.dividend_i = 32'd77; dif.divisor_i = 32'd7;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    dif.ready_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (dif.busy_o !== 1'b0) begin failures++; $display("FAIL drop_busy got=%b exp=0", dif.busy_o); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= dif.valid_o; end
    checks++;
    if (seen !== 1'b0 || dif.quotient_o !== 32'd100 || dif.remainder_o !== 32'd0) begin
      failures++; $display("FAIL drop_retain valid_seen=%b q=%h r=%h exp 0 q=64 r=0", seen, dif.quotient_o, dif.remainder_o);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    @(posedge clk); #1;
    dif.ready_i = 1'b1; dif.signed_i = 1'b0; dif.dividend_i = 32'd100; dif.divisor_i = 32'd7;
    @(posedge clk); #1;
    n = 0;
    while (!dif.valid_o && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (n != 32) begin failures++; $display("FAIL b2b_first latency got=%0d exp=32", n); end
    checks++;
    if (dif.quotient_o !== 32'd14 || dif.remainder_o !== 32'd2) begin
      failures++; $display("FAIL b2b_first result q=%h r=%h exp q=e r=2", dif.quotient_o, dif.remainder_o);
    end
    dif.dividend_i = 32'd9; dif.divisor_i = 32'd3;
    @(posedge clk); #1; n++;
    checks++;
    if (dif.valid_o !== 1'b0 || dif.busy_o !== 1'b0) begin
      failures++; $display("FAIL b2b_gap valid=%b busy=%b exp 0 0", dif.valid_o, dif.busy_o);
    end
    @(posedge clk); #1; n++;
    while (!dif.valid_o && n < 80) begin @(posedge clk); #1; n++; end
    dif.ready_i = 1'b0;
    checks++; if (n != 66) begin failures++; $display("FAIL b2b_second latency got=%0d exp=66", n); end
    checks++;
    if (dif.quotient_o !== 32'd3 || dif.remainder_o !== 32'd0) begin
      failures++; $display("FAIL b2b_second result q=%h r=%h exp q=3 r=0", dif.quotient_o, dif.remainder_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "r_prev");
    @(posedge clk); #1;
    dif.ready_i = 1'b1; dif.signed_i = 1'b0; dif.dividend_i = 32'd100; dif.divisor_i = 32'd7;
    @(posedge clk); #1;
    repeat (19) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({dif.valid_o, dif.busy_o} !== 2'b00 || dif.quotient_o !== 0 || dif.remainder_o !== 0) begin
      failures++; $display("FAIL async_reset valid=%b busy=%b q=%h r=%h exp all 0", dif.valid_o, dif.busy_o, dif.quotient_o, dif.remainder_o);
    end
    dif.ready_i = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_div(32'd1234567, 32'd1000, 1'b0, 32'd1234, 32'd567, "r_after");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fairy_div_unit.md
Name: fairy_div_unit

Overview:
Iterative radix-2 restoring divider acting as the responder behind the execute stage's divide handshake. The execute stage raises ready_i and holds it, stalling, until valid_o, then captures {remainder_o, quotient_o} into its HI/LO result on that same edge. Supports unsigned (DIVU) and signed (DIV) operands. Adds an explicit flush so that exceptions and ERET cancel an in-flight divide.

Parameters:
WIDTH, 32, operand and result width; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
ready_i  input  1  divide request; held high by the requester until valid_o
signed_i  input  1  1 = signed DIV, 0 = unsigned DIVU; sampled at start
flush_i  input  1  synchronous abort (exception/ERET); highest priority after reset
dividend_i  input  WIDTH  dividend (rs); sampled at start
divisor_i  input  WIDTH  divisor (rt); sampled at start
valid_o  output  1  result valid; one-cycle pulse
busy_o  output  1  high while in BUSY or DONE
quotient_o  output  WIDTH  quotient; holds the last result
remainder_o  output  WIDTH  remainder; holds the last result

Behaviour:
- Reset: state = IDLE, valid_o = 0, busy_o = 0, quotient_o = 0, remainder_o = 0, iteration counter = 0.
- States:
  - IDLE -> BUSY when ready_i = 1 and flush_i = 0. On that edge, latch |dividend|, |divisor|, the quotient sign (sign(a) XOR sign(b), signed only) and the remainder sign (sign(a), signed only). Clear the partial remainder and set count = 0.
  - BUSY: one iteration per cycle. Shift {rem, quo} left by 1. trial = rem - divisor (WIDTH+1 bits). If trial is non-negative, rem = trial and quo[0] = 1; otherwise quo[0] = 0. After iteration WIDTH-1, go to DONE.
  - DONE: valid_o = 1 for exactly this cycle. quotient_o and remainder_o are registered with sign-corrected values on the BUSY->DONE edge. Then go to IDLE unconditionally; ready_i is ignored in DONE.
- Latency: ready_i first sampled high at edge T. BUSY spans cycles T+1..T+32. valid_o is high in cycle T+33.
- Back-to-back: if ready_i is high in the IDLE cycle after DONE, a new divide starts. No idle gap beyond that single IDLE cycle.
- Abort: flush_i = 1 in any state -> IDLE on the next edge. The same happens if ready_i drops during BUSY. No valid_o is produced; quotient_o and remainder_o keep their previous values.
- Sign correction (signed only):
  - Quotient is negated if the quotient sign is set.
  - Remainder is negated if the dividend was negative.
  - Magnitudes use unsigned WIDTH arithmetic, so -2^31 / -1 yields q = 0x80000000, r = 0, with no trap.
- Divide by zero: no exception. Unsigned: q = all ones, r = dividend. Signed: the natural restoring result followed by sign correction, with no special casing.
- Inputs are sampled only on the IDLE->BUSY edge. Operand changes during BUSY are ignored.
- Asynchronous reset mid-operation: immediate IDLE, all outputs 0.

Decomposition:
- Shared package fairy_div_pkg: state encoding (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2) and the DIV_ITER constant (= WIDTH).
- Optional sub-module fairy_div_step: one combinational restoring iteration (rem, quo, divisor in; next rem, next quo out). Keep it combinational so BUSY uses one instance.
- Everything else stays in the top module.

Test Plan:
- Unsigned: ready_i = 1, signed_i = 0, 100 / 7 at edge T -> valid_o high only in cycle T+33, q = 14, r = 2. Outputs hold after the pulse.
- Signed: -7 / 2 (0xFFFFFFF9 / 0x2) -> q = 0xFFFFFFFD, r = 0xFFFFFFFF. Also 7 / -2 -> q = 0xFFFFFFFD, r = 1.
- Corners:
  - signed 0x80000000 / 0xFFFFFFFF -> q = 0x80000000, r = 0.
  - unsigned 5 / 0 -> q = 0xFFFFFFFF, r = 5.
  - unsigned 0xFFFFFFFF / 1 -> q = 0xFFFFFFFF, r = 0.
- Flush:
  - flush_i pulsed at T+10 -> no valid_o. busy_o is low from T+11. Outputs retain the previous result.
  - Re-request at T+12 -> valid_o at T+45.
- Back-to-back: ready_i held high across two requests (100/7 then 9/3) -> valid_o at T+33 and T+67, with results 14,2 then 3,0.
- Reset: reset_n low at T+20 asynchronously -> all outputs 0 immediately. After release with ready_i = 1, a fresh 33-cycle divide completes correctly.
